pa_ctrl: RTL

- Multi-channel power-amplifier controller on the SoC CPU native bus.
- Per-channel enable requests, mode words and a programmable settle time.
- Each channel runs its own power-up/power-down sequencer, so PA rails are never toggled without a settle window.
- Mode changes reach a channel's outputs only at power-up.

---
 rtl/pa_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pa_ctrl.sv
// Multi-channel PA controller: CPU register block plus one power-up/power-down
// sequencer per channel, so rails never toggle without a settle window.
module pa_ctrl #(
  parameter int N_CH       = 2,
  parameter int MODE_W     = 2,
  parameter int DATA_W     = 32,
  parameter int SETTLE_W   = 16,
  parameter int SETTLE_RST = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [1:0]               address,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wstrb,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic [N_CH-1:0]          pd,
  output logic [N_CH*MODE_W-1:0]   mode,
  output logic [N_CH-1:0]          on
);

  localparam int MW = N_CH * MODE_W;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_RST);

  localparam logic [1:0] S_OFF       = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_ON        = 2'd2;
  localparam logic [1:0] S_RAMP_DOWN = 2'd3;

  logic [N_CH-1:0]     ctrl_reg;
  logic [MW-1:0]       mode_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [N_CH-1:0]     busy;
  logic [DATA_W-1:0]   read_data;
  logic                accept;

  // A held valid during the ready cycle must not start a second access.
  assign accept = valid && !ready;

  always_comb begin
    read_data = '0;
    case (address)
      2'd0: read_data[N_CH-1:0]     = ctrl_reg;
      2'd1: read_data[MW-1:0]       = mode_reg;
      2'd2: read_data[SETTLE_W-1:0] = settle_reg;
      default: begin
        read_data[N_CH-1:0]      = on;
        read_data[2*N_CH-1:N_CH] = busy;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready      <= 1'b0;
      rdata      <= '0;
      ctrl_reg   <= '0;
      mode_reg   <= '0;
      settle_reg <= SETTLE_INIT;
    end else begin
      ready <= accept;
      if (accept) begin
        if (wstrb) begin
          case (address)
            2'd0:    ctrl_reg   <= wdata[N_CH-1:0];
            2'd1:    mode_reg   <= wdata[MW-1:0];
            2'd2:    settle_reg <= wdata[SETTLE_W-1:0];
            default: ;
          endcase
        end else begin
          rdata <= read_data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [1:0]          state;
    logic [SETTLE_W-1:0] cnt;
    logic                pd_ch;
    logic                on_ch;
    logic [MODE_W-1:0]   mode_ch;

    // Settle time and mode are captured at ramp entry; later register writes wait.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= S_OFF;
        cnt     <= '0;
        pd_ch   <= 1'b1;
        on_ch   <= 1'b0;
        mode_ch <= '0;
      end else begin
        case (state)
          S_OFF: begin
            if (ctrl_reg[gi]) begin
              mode_ch <= mode_reg[gi*MODE_W +: MODE_W];
              cnt     <= settle_reg;
              pd_ch   <= 1'b0;
              state   <= S_RAMP_UP;
            end
          end
          S_RAMP_UP: begin
            if (!ctrl_reg[gi]) begin
              pd_ch <= 1'b1;
              cnt   <= settle_reg;
              state <= S_RAMP_DOWN;
            end else if (cnt == '0) begin
              on_ch <= 1'b1;
              state <= S_ON;
            end else begin
              cnt <= cnt - SETTLE_W'(1);
            end
          end
          S_ON: begin
            if (!ctrl_reg[gi]) begin
              on_ch <= 1'b0;
              pd_ch <= 1'b1;
              cnt   <= settle_reg;
              state <= S_RAMP_DOWN;
            end
          end
          default: begin
            if (cnt == '0) begin
              state <= S_OFF;
            end else begin
              cnt <= cnt - SETTLE_W'(1);
            end
          end
        endcase
      end
    end

    assign busy[gi]                   = (state == S_RAMP_UP) || (state == S_RAMP_DOWN);
    assign pd[gi]                     = pd_ch;
    assign on[gi]                     = on_ch;
    assign mode[gi*MODE_W +: MODE_W]  = mode_ch;
  end

endmodule
